// File: rtl/fetch_ctrl.sv
// fetch_ctrl: pc sequencer feeding a small prefetch FIFO with redirect flush and start/halt run control
module fetch_ctrl #(
  parameter int PC_W = 8,
  parameter int OP_W = 16,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  output logic [PC_W-1:0] imem_pc,
  input  logic [OP_W-1:0] imem_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_op,
  output logic [PC_W-1:0] out_pc,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [AW:0] count;
  logic [AW-1:0] rd, wr;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [OP_W-1:0] op_mem [DEPTH];
  logic pop, push, flush;
  assign imem_pc = pc;
  assign busy = state == RUN;
  assign out_valid = count != '0;
  assign out_op = out_valid ? op_mem[rd] : '0;
  assign out_pc = out_valid ? pc_mem[rd] : '0;
  assign pop = out_valid && out_ready;
  assign flush = redir_valid || (halt && state != IDLE);
  assign push = busy && !flush && (count < (AW+1)'(DEPTH) || pop);
  always_comb begin
    state_n = state;
    pc_n = push ? pc + PC_W'(1) : pc;
    if (redir_valid) begin
      pc_n = redir_pc;
      state_n = busy && halt ? HALTED : state;
    end else if (halt && state != IDLE) begin
      state_n = HALTED;
    end else if (start && !busy) begin
      state_n = RUN;
      pc_n = state == IDLE ? RESET_PC : pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      count <= flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      rd <= flush ? '0 : rd + AW'(pop);
      wr <= flush ? '0 : wr + AW'(push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr] <= pc;
      op_mem[wr] <= imem_op;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, stall sequence and randomized run against a queue-based model
module tb_fetch_ctrl;
  logic clk = 0, rst, start, halt, out_ready, redir_valid, out_valid, busy;
  logic [7:0] imem_pc, out_pc, redir_pc;
  logic [15:0] imem_op, out_op;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] imem(logic [7:0] a);
    return {~a, a ^ 8'h3C};
  endfunction
  assign imem_op = imem(imem_pc);

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_pc(imem_pc), .imem_op(imem_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .busy(busy)
  );

  typedef struct {logic [7:0] pc; logic [15:0] op;} ent_t;
  ent_t q[$];
  int mode;
  logic [7:0] mpc;

  task automatic model_step(input logic r, s, h, rdy, rv, input logic [7:0] rp);
    if (r) begin
      mode = 0;
      mpc = 0;
      q.delete();
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (rv) begin
        q.delete();
        mpc = rp;
        if (mode == 1 && h) mode = 2;
      end else if (h && mode != 0) begin
        q.delete();
        mode = 2;
      end else if (s && mode != 1) begin
        if (mode == 0) mpc = 0;
        mode = 1;
      end else if (mode == 1 && q.size() < 2) begin
        q.push_back('{mpc, imem(mpc)});
        mpc = mpc + 8'd1;
      end
    end
  endtask

  task automatic apply(input logic r, s, h, rdy, rv, input logic [7:0] rp);
    rst = r; start = s; halt = h; out_ready = rdy; redir_valid = rv; redir_pc = rp;
    @(posedge clk);
    model_step(r, s, h, rdy, rv, rp);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask

  task automatic chk_model();
    logic v;
    v = q.size() != 0;
    chk("valid", 32'(out_valid), 32'(v));
    chk("out_pc", 32'(out_pc), v ? 32'(q[0].pc) : 0);
    chk("out_op", 32'(out_op), v ? 32'(q[0].op) : 0);
    chk("busy", 32'(busy), 32'(mode == 1));
    chk("imem_pc", 32'(imem_pc), 32'(mpc));
  endtask

  typedef struct {
    logic r, s, h, rdy, rv;
    logic [7:0] rp;
    logic v;
    logic [7:0] opc;
    logic b;
    logic [7:0] ipc;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl = '{
      '{0,1,0,1,0,  0, 0,  0,0,  0},
      '{0,0,0,1,0,  0, 0,  0,1,  0},
      '{0,0,0,1,0,  0, 1,  0,1,  1},
      '{0,0,0,1,0,  0, 1,  1,1,  2},
      '{0,0,0,0,0,  0, 1,  2,1,  3},
      '{0,0,0,0,0,  0, 1,  2,1,  4},
      '{0,0,0,0,0,  0, 1,  2,1,  4},
      '{0,0,0,1,0,  0, 1,  2,1,  4},
      '{0,0,0,1,0,  0, 1,  3,1,  5},
      '{0,0,0,1,1, 20, 1,  4,1,  6},
      '{0,0,0,1,0,  0, 0,  0,1, 20},
      '{0,0,0,1,0,  0, 1, 20,1, 21},
      '{0,0,1,0,0,  0, 1, 21,1, 22},
      '{0,1,0,0,0,  0, 0,  0,0, 22},
      '{0,0,0,0,0,  0, 0,  0,1, 22},
      '{0,0,0,1,0,  0, 1, 22,1, 23},
      '{0,0,1,0,1,  9, 1, 23,1, 24},
      '{0,1,0,0,0,  0, 0,  0,0,  9},
      '{0,0,0,1,0,  0, 0,  0,1,  9},
      '{0,0,0,1,0,  0, 1,  9,1, 10},
      '{1,0,0,1,0,  0, 1, 10,1, 11},
      '{0,1,0,0,1,254, 0,  0,0,  0},
      '{0,1,0,0,0,  0, 0,  0,0,254},
      '{0,0,1,0,0,  0, 0,  0,1,  0},
      '{0,0,0,0,1,254, 0,  0,0,  0},
      '{0,1,0,0,0,  0, 0,  0,0,254},
      '{0,0,0,1,0,  0, 0,  0,1,254},
      '{0,0,0,1,0,  0, 1,254,1,255},
      '{0,0,0,1,0,  0, 1,255,1,  0},
      '{0,0,0,1,0,  0, 1,  0,1,  1},
      '{0,0,0,1,0,  0, 1,  1,1,  2},
      '{1,0,0,1,0,  0, 1,  2,1,  3},
      '{0,0,1,0,0,  0, 0,  0,0,  0},
      '{0,0,0,0,0,  0, 0,  0,0,  0}
    };
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d.out_pc", i), 32'(out_pc), 32'(tbl[i].opc));
      chk($sformatf("v%0d.out_op", i), 32'(out_op), tbl[i].v ? 32'(imem(tbl[i].opc)) : 0);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("v%0d.imem_pc", i), 32'(imem_pc), 32'(tbl[i].ipc));
      apply(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].rdy, tbl[i].rv, tbl[i].rp);
    end
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall.out_pc", 32'(out_pc), 0);
      chk("stall.imem_pc", 32'(imem_pc), i == 0 ? 1 : 2);
      apply(0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      chk("resume.valid", 32'(out_valid), 1);
      chk("resume.out_pc", 32'(out_pc), 32'(i));
      apply(0, 0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 400; i++) begin
      chk_model();
      apply($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(15) == 0,
            $urandom_range(3) != 0, $urandom_range(9) == 0, 8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
